// File: rtl/car_sensor_filter.sv
// Loop-detector conditioning: sync, prescaled debounce, request latch, car count.
// Optional stuck-high fail-safe when SENSOR_FAULT_EN is defined.
module car_sensor_filter #(
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FAULT_TICKS    = 255
) (
  input  logic       quartzClock,
  input  logic       nReset,
  input  logic       rawSensor,
  input  logic       lightGreen,
  output logic       carDetected,
  output logic [3:0] carCount,
  output logic       sensorFault
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [PW-1:0] PMAX  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQUEST,
    SERVING
  } state_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] deb_q, deb_d;
  logic          stable_q, stable_d;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          det_q, det_d;
  logic          tick;
  logic          arrival;
  logic [3:0]    cnt_inc;

  always_comb begin
    sync1_d  = rawSensor;
    sync2_d  = sync1_q;
    tick     = (presc_q == PMAX);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    deb_d    = deb_q;
    stable_d = stable_q;
    if (tick) begin
      if (sync2_q != stable_q) begin
        if (deb_q == DLAST) begin
          stable_d = sync2_q;
          deb_d    = '0;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end else begin
        deb_d = '0;
      end
    end
    // arrival fires in the cycle stable is about to rise
    arrival = stable_d & ~stable_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    unique case (state_q)
      IDLE: begin
        if (arrival && !lightGreen) begin
          state_d = REQUEST;
          cnt_d   = cnt_inc;
        end
      end
      REQUEST: begin
        if (lightGreen) begin
          state_d = SERVING;
          cnt_d   = 4'd0;
        end else if (arrival) begin
          cnt_d = cnt_inc;
        end
      end
      SERVING: begin
        if (!lightGreen) begin
          state_d = stable_q ? REQUEST : IDLE;
          cnt_d   = stable_q ? 4'd1 : 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    det_d = (state_d == REQUEST);
  end

  always_ff @(posedge quartzClock or negedge nReset) begin
    if (!nReset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      presc_q  <= '0;
      deb_q    <= '0;
      stable_q <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      det_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      presc_q  <= presc_d;
      deb_q    <= deb_d;
      stable_q <= stable_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      det_q    <= det_d;
    end
  end

  assign carCount = cnt_q;

`ifdef SENSOR_FAULT_EN
  localparam int FW = $clog2(FAULT_TICKS + 1);
  localparam logic [FW-1:0] FMAX = FW'(FAULT_TICKS);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fault_q, fault_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    fault_d = fault_q;
    if (tick) begin
      if (stable_q) begin
        if (fcnt_q != FMAX) fcnt_d = fcnt_q + 1'b1;
      end else begin
        fcnt_d = '0;
      end
    end
    if (fcnt_d == FMAX) fault_d = 1'b1;
  end

  always_ff @(posedge quartzClock or negedge nReset) begin
    if (!nReset) begin
      fcnt_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      fcnt_q  <= fcnt_d;
      fault_q <= fault_d;
    end
  end

  // fail-safe: keep the controller cycling once the loop is stuck
  assign sensorFault = fault_q;
  assign carDetected = det_q | fault_q;
`else
  assign sensorFault = 1'b0;
  assign carDetected = det_q;
`endif

endmodule

// File: tb/tb_car_sensor_filter.sv
// Scoreboard bench for car_sensor_filter (TICK_DIV=4, DEBOUNCE_TICKS=3, FAULT_TICKS=20).
module tb_car_sensor_filter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw = 1'b1;
  logic       green = 1'b0;
  logic       det;
  logic [3:0] cnt;
  logic       fault;

`ifdef SENSOR_FAULT_EN
  localparam int FEXP = 1;
`else
  localparam int FEXP = 0;
`endif

  car_sensor_filter #(
    .TICK_DIV(4),
    .DEBOUNCE_TICKS(3),
    .FAULT_TICKS(20)
  ) dut (
    .quartzClock(clk),
    .nReset(rst_n),
    .rawSensor(raw),
    .lightGreen(green),
    .carDetected(det),
    .carCount(cnt),
    .sensorFault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       det;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic push(input string tag, input logic d, input logic [3:0] c);
    exp_t e;
    e.tag = tag;
    e.det = d;
    e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_det"}, int'(det), int'(e.det));
      chk({e.tag, "_cnt"}, int'(cnt), int'(e.cnt));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arrive();
    raw = 1'b1;
    cyc(20);
    raw = 1'b0;
    cyc(20);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=0 want=1");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int rises;
    logic prev;

    // reset with raw high
    #12;
    chk("rst_det", int'(det), 0);
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_fault", int'(fault), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push("first", 1'b1, 4'd1);
    n = 0;
    while (!det && n < 40) begin
      cyc(1);
      n++;
    end
    chk("latency_in_window", int'(n >= 12 && n <= 18), 1);
    sb_check();

    // serve it and return to idle
    green = 1'b1;
    cyc(1);
    raw = 1'b0;
    cyc(25);
    green = 1'b0;
    cyc(1);
    push("idle0", 1'b0, 4'd0);
    sb_check();

    // bounce: 2 ticks high, 1 tick low, 5 times
    rises = 0;
    prev = det;
    for (int k = 0; k < 5; k++) begin
      raw = 1'b1;
      for (int j = 0; j < 8; j++) begin
        cyc(1);
        if (det && !prev) rises++;
        prev = det;
      end
      raw = 1'b0;
      for (int j = 0; j < 4; j++) begin
        cyc(1);
        if (det && !prev) rises++;
        prev = det;
      end
    end
    cyc(20);
    chk("bounce_rises", rises, 0);
    push("bounce", 1'b0, 4'd0);
    sb_check();

    // 17 arrivals, count saturates at 15
    for (int i = 1; i <= 17; i++) begin
      push($sformatf("arr%0d", i), 1'b1, 4'((i > 15) ? 15 : i));
      arrive();
      sb_check();
    end
    green = 1'b1;
    cyc(1);
    push("served", 1'b0, 4'd0);
    sb_check();

    // car still waiting when green drops
    raw = 1'b1;
    cyc(20);
    push("serving_ign", 1'b0, 4'd0);
    sb_check();
    green = 1'b0;
    cyc(1);
    push("still_wait", 1'b1, 4'd1);
    sb_check();
    raw = 1'b0;
    cyc(20);
    green = 1'b1;
    cyc(1);
    push("serve2", 1'b0, 4'd0);
    sb_check();
    green = 1'b0;
    cyc(1);
    push("no_wait", 1'b0, 4'd0);
    sb_check();

    // arrival during green in idle
    green = 1'b1;
    arrive();
    push("green_on", 1'b0, 4'd0);
    sb_check();
    green = 1'b0;
    cyc(1);
    push("green_off", 1'b0, 4'd0);
    sb_check();

    // stuck-high sensor
    raw = 1'b1;
    cyc(130);
    push("stuck_req", 1'b1, 4'd1);
    sb_check();
    chk("stuck_fault", int'(fault), FEXP);
    green = 1'b1;
    cyc(1);
    push("stuck_serv", FEXP[0], 4'd0);
    sb_check();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_fault", int'(fault), 0);
    chk("async_rst_det", int'(det), 0);
    chk("async_rst_cnt", int'(cnt), 0);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/car_sensor_filter.md
Name: car_sensor_filter

Overview:
- Upstream conditioning stage for the traffic-light controller. Takes the raw, asynchronous, bouncy loop-detector input and produces the clean `carDetected` request the controller consumes.
- Synchronizes and debounces the raw input on a prescaled sample tick.
- Latches a service request until the controller shows green, and counts waiting cars.
- Optionally flags a stuck-high sensor and fails safe.

Parameters:
- TICK_DIV, 1000, `quartzClock` cycles per sample tick (min 2).
- DEBOUNCE_TICKS, 4, consecutive disagreeing ticks needed to change the debounced level (min 1).
- FAULT_TICKS, 255, consecutive ticks of debounced-high needed to declare a stuck sensor (min 2).

Ports:
- quartzClock  in  1  system clock; all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- rawSensor  in  1  raw loop-detector level; asynchronous, may bounce.
- lightGreen  in  1  controller green output; serves as service acknowledge.
- carDetected  out  1  registered request to the controller.
- carCount  out  4  cars arrived since last service, saturating at 15.
- sensorFault  out  1  sticky stuck-high flag.

Behaviour:
- Reset (async, `nReset`=0):
  - Sync flops, prescaler, debounce counter, fault counter and debounced level `stable` all clear to 0.
  - State=IDLE, `carDetected`=0, `carCount`=0, `sensorFault`=0.
  - Reset asserted mid-operation aborts everything immediately. No request survives reset.
- Synchronizer: 2-flop on `rawSensor`, giving `syncS`.
- Prescaler: counts 0..TICK_DIV-1 and wraps. `tick` is a 1-cycle pulse in the cycle the count equals TICK_DIV-1.
- Debounce (evaluated on `tick` only):
  - `syncS`≠`stable`: debCount++. When debCount reaches DEBOUNCE_TICKS, `stable`←`syncS` and debCount←0.
  - `syncS`==`stable`: debCount←0.
- Arrival: 1-cycle pulse on a 0→1 transition of `stable`.
- Latency: `rawSensor` edge to `carDetected` rise is 2 cycles (sync), plus DEBOUNCE_TICKS ticks, plus 1 cycle (registered FSM output).
- FSM:
  - IDLE (`carDetected`=0):
    - arrival with `lightGreen`=0 → REQUEST, `carCount`++.
    - arrival with `lightGreen`=1 → stay IDLE, no count (car passes on current green).
  - REQUEST (`carDetected`=1):
    - each arrival: `carCount`++ (saturate at 15).
    - `lightGreen`=1 → SERVING, `carCount`←0 in the same cycle. A simultaneous arrival is discarded.
  - SERVING (`carDetected`=0):
    - arrivals ignored.
    - on `lightGreen`=0: → REQUEST with `carCount`←1 if `stable`=1 (car still waiting); otherwise → IDLE.
- Width rules: `carCount` never wraps; 15+1 = 15.
- `lightGreen` is used level-sensitive. It is assumed synchronous to `quartzClock` (driven by the same-clock controller).

Optional Feature:
- Macro: SENSOR_FAULT_EN.
- Defined:
  - Fault counter increments on each `tick` with `stable`=1 and clears on any `tick` with `stable`=0.
  - On reaching FAULT_TICKS, `sensorFault`←1, sticky until reset.
  - While `sensorFault`=1, `carDetected` is forced to 1 in every state. This keeps the controller cycling (fail-safe). The FSM and `carCount` continue to run normally underneath.
- Not defined:
  - Fault counter is absent and `sensorFault` is a constant 0.
  - `carDetected` is driven purely by the FSM.

Test Plan:
Test parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, FAULT_TICKS=20.
- Reset: `nReset`=0 with `rawSensor`=1 → all outputs 0. Release → `carDetected` rises exactly 2 + 3×4 (±3 for prescaler phase) + 1 cycles later; `carCount`=1.
- Bounce reject: `rawSensor` high for 2 ticks, low 1 tick, repeated 5× → `stable` never changes, `carDetected`=0, `carCount`=0.
- Multiple arrivals: 17 clean arrivals while `lightGreen`=0 → `carCount` saturates at 15, `carDetected` stays 1. Then `lightGreen`=1 → next cycle `carDetected`=0 and `carCount`=0.
- Car still waiting at end of green: in SERVING with `rawSensor` held high, drop `lightGreen` → next cycle REQUEST, `carDetected`=1, `carCount`=1. Repeat with `rawSensor` low → IDLE, `carDetected`=0.
- Green already on: arrival while `lightGreen`=1 in IDLE → `carDetected` stays 0, `carCount` stays 0.
- Stuck sensor (SENSOR_FAULT_EN defined): `rawSensor` held 1 for 3 + 20 ticks → `sensorFault`=1, and `carDetected`=1 even during SERVING. Assert `nReset` mid-run → `sensorFault`=0 immediately. Same stimulus with the macro undefined → `sensorFault` stays 0.
